avalon_body_regs: RTL and testbench

- Parametrised Avalon-MM slave that holds the per-body render parameters (radius, x, y, z) for NUM_BODIES bodies, plus a per-body enable mask.
- Software writes a shadow register bank. Shadow contents move to the active bank atomically, only at the start of vertical blanking, so ball renderers never see a half-updated frame.
- Provides commit handshake, per-frame interrupt and frame counter. Sits between the HPS/NIOS Avalon bus and the array of ball renderers.

---
 rtl/avalon_body_regs_if.sv | 23 ++
 rtl/avalon_body_regs.sv | 150 +++++++++++++++
 tb/tb_avalon_body_regs.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/avalon_body_regs_if.sv
// Avalon-MM slave bus bundle for the body-parameter register block.
// The master drives the strobes, address and write data; the slave returns read data.
interface avalon_body_regs_if #(
  parameter int ADDR_W = 5
);
  logic              read;
  logic              write;
  logic              cs;
  logic [3:0]        byte_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output read, write, cs, byte_en, addr, writedata,
    input  readdata
  );

  modport slave (
    input  read, write, cs, byte_en, addr, writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_body_regs.sv
// Double-buffered per-body render parameters: software fills a shadow bank that is
// copied to the active bank in one cycle at the start of vertical blanking.
module avalon_body_regs #(
  parameter int NUM_BODIES = 4,
  parameter int ADDR_W     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  avalon_body_regs_if.slave         avl,
  input  logic                      vga_vs,
  output logic [NUM_BODIES*128-1:0] body_data,
  output logic [NUM_BODIES-1:0]     body_en,
  output logic                      commit_pending,
  output logic                      frame_irq
);
  localparam int NUM_WORDS   = 4 * NUM_BODIES;
  localparam int MASK_ADDR   = NUM_WORDS;
  localparam int CTRL_ADDR   = NUM_WORDS + 1;
  localparam int STATUS_ADDR = NUM_WORDS + 2;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    return merged;
  endfunction

  logic [31:0]           shadow_regs [NUM_WORDS];
  logic [NUM_BODIES-1:0] shadow_en;
  logic                  pending;
  logic                  irq_en;
  logic                  auto_commit;
  logic                  irq_flag;
  logic [15:0]           frame_cnt;
  logic [2:0]            vs_sync;
  logic                  vblank;

  logic [ADDR_W-1:0]     addr;
  int                    addr_idx;
  logic                  wr_en;
  logic                  rd_en;
  logic                  commit_req;
  logic                  irq_clear;
  logic                  do_commit;
  logic [31:0]           en_word;
  logic [31:0]           ctrl_word;
  logic [31:0]           status_word;
  logic [31:0]           rd_mux;

  assign addr       = avl.addr;
  assign addr_idx   = int'(addr);
  assign wr_en      = avl.cs & avl.write;
  assign rd_en      = avl.cs & avl.read;
  assign commit_req = wr_en && (addr_idx == CTRL_ADDR) && avl.byte_en[0] && avl.writedata[0];
  assign irq_clear  = wr_en && (addr_idx == STATUS_ADDR) && avl.byte_en[0] && avl.writedata[1];
  assign do_commit  = vblank & (pending | auto_commit);

  assign ctrl_word   = {29'd0, auto_commit, irq_en, pending};
  assign status_word = {frame_cnt, 14'd0, irq_flag, pending};

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    en_word                 = '0;
    en_word[NUM_BODIES-1:0] = shadow_en;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      if (addr_idx == i) rd_mux = shadow_regs[i];
    if (addr_idx == MASK_ADDR)   rd_mux = en_word;
    if (addr_idx == CTRL_ADDR)   rd_mux = ctrl_word;
    if (addr_idx == STATUS_ADDR) rd_mux = status_word;
  end

  // vs_sync[1:0] is the two-flop synchroniser, vs_sync[2] the previous synchronised
  // level; preset high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_sync <= 3'b111;
      vblank  <= 1'b0;
    end else begin
      vs_sync <= {vs_sync[1:0], vga_vs};
      vblank  <= vs_sync[2] & ~vs_sync[1];
    end
  end

  // NOTE: the shadow bank is reset element by element because software may read
  // it back before ever writing it; registers use non-blocking '<=' throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) shadow_regs[i] <= '0;
      shadow_en <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_WORDS; i++)
        if (addr_idx == i)
          shadow_regs[i] <= merge_bytes(shadow_regs[i], avl.writedata, avl.byte_en);
      if (addr_idx == MASK_ADDR)
        for (int i = 0; i < NUM_BODIES; i++)
          if (avl.byte_en[i/8]) shadow_en[i] <= avl.writedata[i];
    end
  end

  // Active bank samples the shadow bank as it stood before any same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      body_data <= '0;
      body_en   <= '0;
    end else if (do_commit) begin
      for (int k = 0; k < NUM_BODIES; k++)
        for (int j = 0; j < 4; j++)
          body_data[128*k + 32*j +: 32] <= shadow_regs[4*k + j];
      body_en <= shadow_en;
    end
  end

  // A commit request written during the vblank pulse survives the pulse's clear,
  // and a commit's flag set beats a same-cycle clear: later assignments win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending     <= 1'b0;
      irq_en      <= 1'b0;
      auto_commit <= 1'b0;
      irq_flag    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      if (wr_en && (addr_idx == CTRL_ADDR) && avl.byte_en[0]) begin
        irq_en      <= avl.writedata[1];
        auto_commit <= avl.writedata[2];
      end
      if (vblank) frame_cnt <= frame_cnt + 16'd1;
      if (do_commit) pending <= 1'b0;
      if (commit_req) pending <= 1'b1;
      if (irq_clear) irq_flag <= 1'b0;
      if (do_commit) irq_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) avl.readdata <= '0;
    else     avl.readdata <= rd_en ? rd_mux : '0;
  end

  assign commit_pending = pending;
  assign frame_irq      = irq_flag & irq_en;
endmodule

// File: tb/tb_avalon_body_regs.sv
// Directed bench for avalon_body_regs (NUM_BODIES=4): register access, byte lanes,
// vblank-synchronised commit, simultaneous-event ordering, counter wrap and reset.
module tb_avalon_body_regs;
  localparam int N      = 4;
  localparam int ADDR_W = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           vga_vs = 1'b1;
  logic [N*128-1:0] body_data;
  logic [N-1:0]   body_en;
  logic           commit_pending;
  logic           frame_irq;

  int n_checks = 0;
  int n_pass   = 0;

  avalon_body_regs_if #(.ADDR_W(ADDR_W)) avl ();

  avalon_body_regs #(.NUM_BODIES(N), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .avl            (avl.slave),
    .vga_vs         (vga_vs),
    .body_data      (body_data),
    .body_en        (body_en),
    .commit_pending (commit_pending),
    .frame_irq      (frame_irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic bus_idle();
    avl.read = 1'b0; avl.write = 1'b0; avl.cs = 1'b0;
    avl.byte_en = 4'h0; avl.addr = '0; avl.writedata = '0;
  endtask

  task automatic drive_write(input int a, input logic [31:0] d, input logic [3:0] be);
    avl.cs = 1'b1; avl.write = 1'b1; avl.read = 1'b0;
    avl.addr = ADDR_W'(a); avl.writedata = d; avl.byte_en = be;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    @(negedge clk);
    drive_write(a, d, be);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    @(negedge clk);
    avl.cs = 1'b1; avl.read = 1'b1; avl.write = 1'b0; avl.addr = ADDR_W'(a);
    @(negedge clk);
    d = avl.readdata;
    bus_idle();
  endtask

  // One full VS low/high period; the commit edge lands four clocks after the fall.
  task automatic vs_pulse();
    @(negedge clk);
    vga_vs = 1'b0;
    repeat (4) @(negedge clk);
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Places a bus write on exactly the clock edge where the vblank pulse is acted on.
  task automatic vblank_write(input int a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    vga_vs = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive_write(a, d, be);
    @(negedge clk);
    bus_idle();
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [31:0] rd;

  initial begin
    bus_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_body_data", 128'(body_data), '0);
    check("rst_body_en", 128'(body_en), '0);
    check("rst_frame_irq", 128'(frame_irq), '0);
    check("rst_pending", 128'(commit_pending), '0);
    bus_read(18, rd);
    check("rst_status", 128'(rd), 128'h0);

    // Shadow write without commit: active bank holds, counter advances.
    bus_write(5, 32'h0000_001E);
    repeat (3) vs_pulse();
    bus_read(5, rd);
    check("shadow_x1", 128'(rd), 128'h1E);
    @(negedge clk);
    check("readdata_idle", 128'(avl.readdata), '0);
    check("active_x1_held", 128'(body_data[191:160]), '0);
    bus_read(18, rd);
    check("frame_cnt_3", 128'(rd[31:16]), 128'd3);
    check("status_3", 128'(rd), 128'h0003_0000);

    // Byte-lane writes.
    bus_write(5, 32'h0);
    bus_write(5, 32'h1234_5678, 4'b0100);
    bus_read(5, rd);
    check("be_0100", 128'(rd), 128'h0034_0000);
    bus_write(5, 32'hAAAA_AAAA, 4'b0001);
    bus_read(5, rd);
    check("be_0001", 128'(rd), 128'h0034_00AA);
    bus_write(5, 32'hFFFF_FFFF, 4'b0000);
    bus_read(5, rd);
    check("be_0000", 128'(rd), 128'h0034_00AA);

    // Requested commit.
    bus_write(0, 32'd10);
    bus_write(1, 32'd100);
    bus_write(2, 32'd200);
    bus_write(3, 32'd50);
    bus_write(16, 32'h1);
    bus_write(17, 32'h3);
    check("pending_set", 128'(commit_pending), 128'd1);
    bus_read(17, rd);
    check("ctrl_read", 128'(rd), 128'h3);
    vs_pulse();
    check("body0_active", body_data[127:0], {32'd50, 32'd200, 32'd100, 32'd10});
    check("body1_x_active", 128'(body_data[191:160]), 128'h0034_00AA);
    check("body_en_active", 128'(body_en), 128'h1);
    check("irq_after_commit", 128'(frame_irq), 128'd1);
    check("pending_cleared", 128'(commit_pending), '0);
    bus_read(18, rd);
    check("status_4", 128'(rd), 128'h0004_0002);
    bus_write(18, 32'h2, 4'b0000);
    check("w1c_no_lanes", 128'(frame_irq), 128'd1);
    bus_write(18, 32'h2);
    check("w1c_clear", 128'(frame_irq), '0);

    // Shadow write in the pulse cycle: active takes the pre-write value.
    bus_write(17, 32'h3);
    vblank_write(1, 32'h77, 4'hF);
    check("sim_write_active", 128'(body_data[63:32]), 128'd100);
    check("sim_write_pending", 128'(commit_pending), '0);
    bus_read(1, rd);
    check("sim_write_shadow", 128'(rd), 128'h77);
    bus_write(18, 32'h2);

    // COMMIT written in the pulse cycle: no commit now, pending afterwards.
    vblank_write(17, 32'h3, 4'hF);
    check("sim_commit_held", 128'(body_data[63:32]), 128'd100);
    check("sim_commit_pending", 128'(commit_pending), 128'd1);
    check("sim_commit_no_irq", 128'(frame_irq), '0);

    // Flag clear in the same cycle as a commit: the set wins.
    vblank_write(18, 32'h2, 4'hF);
    check("sim_w1c_applied", 128'(body_data[63:32]), 128'h77);
    check("sim_w1c_irq", 128'(frame_irq), 128'd1);
    bus_read(18, rd);
    check("status_7", 128'(rd), 128'h0007_0002);

    // AUTO commits every frame without a request.
    bus_write(17, 32'h6);
    bus_write(18, 32'h2);
    bus_write(0, 32'h99);
    vs_pulse();
    check("auto_commit", 128'(body_data[31:0]), 128'h99);
    check("auto_irq", 128'(frame_irq), 128'd1);
    check("auto_no_pending", 128'(commit_pending), '0);
    bus_write(17, 32'h2);

    // Mask upper bits and unmapped addresses read zero.
    bus_write(16, 32'hFFFF_FFFF);
    bus_read(16, rd);
    check("mask_read", 128'(rd), 128'hF);
    bus_write(19, 32'hDEAD_BEEF);
    bus_read(19, rd);
    check("unmapped_read", 128'(rd), '0);

    // Frame counter wrap.
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    bus_read(18, rd);
    check("frame_cnt_ffff", 128'(rd[31:16]), 128'hFFFF);
    vs_pulse();
    bus_read(18, rd);
    check("frame_cnt_wrap", 128'(rd[31:16]), '0);

    // Reset mid-frame drops the pending request.
    bus_write(2, 32'h123);
    bus_write(17, 32'h1);
    check("pre_rst_pending", 128'(commit_pending), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pending", 128'(commit_pending), '0);
    check("rst_mid_active", 128'(body_data), '0);
    rst = 1'b0;
    vs_pulse();
    check("post_rst_no_commit", 128'(body_data), '0);
    check("post_rst_en", 128'(body_en), '0);
    check("post_rst_pending", 128'(commit_pending), '0);
    bus_read(2, rd);
    check("post_rst_shadow", 128'(rd), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
